regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised synchronous register file: one write port and NRD registered read ports.
- Successor to the fixed 32x16, two-read register bank, adding:
  - asynchronous reset of the storage array;
  - per-port read enables with valid flags;
  - configurable write-to-read bypass;
  - out-of-range address detection for non-power-of-two depths.
- Sits between decode (addresses) and the execute stage (operands); writeback drives the write port.

Parameters:
- WIDTH, 16, data width of each register in bits.
- DEPTH, 32, number of registers; need not be a power of two; minimum 2.
- NRD, 2, number of read ports; range 1..8.
- BYPASS, 1, 1 means a same-cycle write to the read address is forwarded to the read data; 0 means the read returns the old contents.
- AW, $clog2(DEPTH), address width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  AW  write address.
- wr_data  input  WIDTH  write data.
- rd_en  input  NRD  per-port read enable.
- rd_addr  input  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rd_data  output  NRD*WIDTH  packed registered read data; port k occupies bits [k*WIDTH +: WIDTH].
- rd_valid  output  NRD  per-port flag: rd_data for that port was updated this cycle.
- addr_err  output  1  one-cycle pulse for any out-of-range access.

Behaviour:
- Reset (rst high, asynchronous):
  - all DEPTH registers clear to 0;
  - rd_data, rd_valid and addr_err clear to 0;
  - takes effect mid-operation without waiting for a clock edge;
  - while rst is high, wr_en and rd_en are ignored.
- Write:
  - on posedge clk with wr_en=1 and wr_addr<DEPTH, R[wr_addr] <= wr_data;
  - visible to a non-bypassed read on the next cycle.
- Read port k:
  - on posedge clk with rd_en[k]=1 and rd_addr_k<DEPTH, rd_data_k <= R[rd_addr_k] and rd_valid[k] <= 1;
  - latency is exactly 1 cycle.
- Read port k, rd_en[k]=0:
  - rd_data_k holds its previous value;
  - rd_valid[k] <= 0.
- Bypass (BYPASS=1), when wr_en=1, wr_addr==rd_addr_k, rd_en[k]=1 and both addresses are in range: rd_data_k <= wr_data in the same edge.
- No bypass (BYPASS=0), same conditions: rd_data_k <= the old R contents.
- Simultaneous reads: any number of ports may read the same address in the same cycle; all receive identical data.
- Out-of-range address (>=DEPTH; possible only when DEPTH is not a power of two):
  - write with wr_en=1: the write is dropped and addr_err <= 1;
  - read with rd_en[k]=1: rd_data_k <= 0, rd_valid[k] <= 1 and addr_err <= 1.
- addr_err:
  - the OR of all write and read error conditions in the cycle;
  - registered, so it appears one cycle after the access;
  - not sticky.
- No internal state machine; there is no backpressure, so every enabled access completes.
- Storage is a plain register array; implement it with flops because of the asynchronous reset.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- When defined, R0 is hardwired to zero:
  - writes to address 0 are silently ignored and do not raise addr_err;
  - reads of address 0 return 0;
  - bypass never forwards into address 0.
- When not defined, R0 is an ordinary register.

Decomposition:
- Shared package regfile_pkg holds:
  - default constants REGFILE_WIDTH=16, REGFILE_DEPTH=32 and REGFILE_NRD=2;
  - the function that computes AW from DEPTH.
- One natural sub-module, regfile_rd_port: one registered read port with bypass and range check, instantiated NRD times in a generate loop.
- Storage and write logic stay in the top module.

Test Plan:
- Reset clear: write 16'hBEEF to R5, then assert rst asynchronously between edges. rd_data, rd_valid and addr_err drop to 0 immediately; a subsequent read of R5 returns 16'h0000.
- Basic write/read: write R3=16'h1234, then on the next cycle read R3 on port 0. One cycle later rd_data_0=16'h1234 and rd_valid[0]=1.
- Bypass: in the same cycle, write R7=16'hA5A5 and read R7 on both ports.
  - BYPASS=1: both ports return 16'hA5A5.
  - BYPASS=0: both ports return the old value 16'h0000.
  - The following cycle, both settings return 16'hA5A5.
- Out-of-range: with DEPTH=20, write addr 25 and read addr 22 on port 1. addr_err pulses for exactly one cycle, rd_data_1=0 and rd_valid[1]=1; R0..R19 are unchanged.
- Hold behaviour: read R3 on port 0, then deassert rd_en[0] while R3 is rewritten. rd_data_0 holds 16'h1234 and rd_valid[0]=0.
- Zero register: with REGFILE_ZERO_REG_EN defined, write R0=16'hFFFF and then read R0. Result is 16'h0000 with addr_err=0. Without the macro, the same sequence returns 16'hFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multiport register file.
package regfile_pkg;

    localparam int REGFILE_WIDTH = 16;
    localparam int REGFILE_DEPTH = 32;
    localparam int REGFILE_NRD   = 2;

    // A depth of 1 would give a zero-width address, so clamp to one bit.
    function automatic int regfile_addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range check, optional write bypass, valid flag.
// REGFILE_ZERO_REG_EN makes address 0 always read as zero.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REGFILE_WIDTH,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int BYPASS = 1,
    parameter int AW     = regfile_addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic in_range;
    logic zero_addr;
    logic wr_hit;

    always_comb begin
        in_range  = {1'b0, rd_addr} < DEPTH_W;
`ifdef REGFILE_ZERO_REG_EN
        zero_addr = (rd_addr == '0);
`else
        zero_addr = 1'b0;
`endif
        wr_hit    = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
        rd_err    = rd_en && !in_range;
    end

    // Out-of-range and hardwired-zero reads take priority over forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!in_range || zero_addr)
                    rd_data <= '0;
                else if (wr_hit)
                    rd_data <= wr_data;
                else
                    rd_data <= mem_data;
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Flop-based register file with one write port and NRD registered read ports.
// REGFILE_ZERO_REG_EN hardwires R0 to zero.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int WIDTH  = REGFILE_WIDTH,
    parameter int DEPTH  = REGFILE_DEPTH,
    parameter int NRD    = REGFILE_NRD,
    parameter int BYPASS = 1,
    parameter int AW     = regfile_addr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]       rd_valid,
    output logic                 addr_err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [NRD-1:0]   rd_err;
    logic             wr_in_range;
    logic             wr_zero;
    logic             wr_err;

    always_comb begin
        wr_in_range = {1'b0, wr_addr} < DEPTH_W;
`ifdef REGFILE_ZERO_REG_EN
        wr_zero     = (wr_addr == '0);
`else
        wr_zero     = 1'b0;
`endif
        wr_err      = wr_en && !wr_in_range;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            addr_err <= 1'b0;
        end else begin
            if (wr_en && wr_in_range && !wr_zero)
                mem[wr_addr] <= wr_data;
            addr_err <= wr_err | (|rd_err);
        end
    end

    // Out-of-range indices yield don't-care data; the port masks it to zero.
    for (genvar k = 0; k < NRD; k++) begin : g_rd_port
        regfile_rd_port #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .BYPASS (BYPASS),
            .AW     (AW)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[k]),
            .rd_addr  (rd_addr[k*AW +: AW]),
            .mem_data (mem[rd_addr[k*AW +: AW]]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[k*WIDTH +: WIDTH]),
            .rd_valid (rd_valid[k]),
            .rd_err   (rd_err[k])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomised, model-checked bench for regfile_multiport, run against two
// configurations: DEPTH=20/BYPASS=1/NRD=2 and DEPTH=32/BYPASS=0/NRD=3.
module tb_regfile_multiport;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif
    localparam int CFG_DEPTH  [2] = '{20, 32};
    localparam int CFG_BYPASS [2] = '{1, 0};
    localparam int CFG_NRD    [2] = '{2, 3};

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_en;
    logic [4:0]  ra [3];
    logic [14:0] rd_addr_bus;

    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_valid;
    logic        a_addr_err;
    logic [47:0] b_rd_data;
    logic [2:0]  b_rd_valid;
    logic        b_addr_err;

    logic [15:0] m_mem     [2][32];
    logic [15:0] exp_data  [2][3];
    logic        exp_valid [2][3];
    logic        exp_err   [2];

    int tests = 0;
    int fails = 0;
    bit check_on = 1'b0;

    assign rd_addr_bus = {ra[2], ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_multiport #(.WIDTH(16), .DEPTH(20), .NRD(2), .BYPASS(1)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en[1:0]),
        .rd_addr  (rd_addr_bus[9:0]),
        .rd_data  (a_rd_data),
        .rd_valid (a_rd_valid),
        .addr_err (a_addr_err)
    );

    regfile_multiport #(.WIDTH(16), .DEPTH(32), .NRD(3), .BYPASS(0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr_bus),
        .rd_data  (b_rd_data),
        .rd_valid (b_rd_valid),
        .addr_err (b_addr_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                                 input logic [2:0] re, input logic [4:0] a0,
                                 input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        ra[0]   = a0;
        ra[1]   = a1;
        ra[2]   = a2;
        @(posedge clk);
        #1;
    endtask

    // Reference: what port k of configuration c must return for the current inputs.
    function automatic logic [15:0] modelRead(input int c, input int k);
        int a;
        a = int'(ra[k]);
        if (a >= CFG_DEPTH[c]) return 16'h0000;
        if (ZERO_REG && a == 0) return 16'h0000;
        if (CFG_BYPASS[c] != 0 && wr_en && int'(wr_addr) == a) return wr_data;
        return m_mem[c][a];
    endfunction

    function automatic logic modelErr(input int c);
        logic e;
        e = wr_en && (int'(wr_addr) >= CFG_DEPTH[c]);
        for (int k = 0; k < CFG_NRD[c]; k++)
            if (rd_en[k] && int'(ra[k]) >= CFG_DEPTH[c]) e = 1'b1;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < 32; i++) m_mem[c][i] <= '0;
                for (int k = 0; k < 3; k++) begin
                    exp_data[c][k]  <= '0;
                    exp_valid[c][k] <= 1'b0;
                end
                exp_err[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < CFG_NRD[c]; k++) begin
                    exp_valid[c][k] <= rd_en[k];
                    if (rd_en[k]) exp_data[c][k] <= modelRead(c, k);
                end
                exp_err[c] <= modelErr(c);
                if (wr_en && int'(wr_addr) < CFG_DEPTH[c] && !(ZERO_REG && wr_addr == 5'd0))
                    m_mem[c][wr_addr] <= wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (check_on) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("a.rd_data[%0d]", k), 32'(a_rd_data[k*16 +: 16]), 32'(exp_data[0][k]));
                checkOutput($sformatf("a.rd_valid[%0d]", k), 32'(a_rd_valid[k]), 32'(exp_valid[0][k]));
            end
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("b.rd_data[%0d]", k), 32'(b_rd_data[k*16 +: 16]), 32'(exp_data[1][k]));
                checkOutput($sformatf("b.rd_valid[%0d]", k), 32'(b_rd_valid[k]), 32'(exp_valid[1][k]));
            end
            checkOutput("a.addr_err", 32'(a_addr_err), 32'(exp_err[0]));
            checkOutput("b.addr_err", 32'(b_addr_err), 32'(exp_err[1]));
        end
    end

    function automatic logic [4:0] rndAddr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0;
        ra[0] = '0; ra[1] = '0; ra[2] = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset a.rd_valid", 32'(a_rd_valid), 32'h0);
        checkOutput("reset b.rd_data", 32'(b_rd_data[31:0]), 32'h0);
        rst = 1'b0;
        check_on = 1'b1;

        // Asynchronous reset mid-cycle clears outputs and storage.
        applyStimulus(1'b1, 5'd5, 16'hBEEF, 3'b000, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b011, 5'd5, 5'd22, 5'd5);
        checkOutput("pre-reset a.rd_data0", 32'(a_rd_data[15:0]), 32'hBEEF);
        checkOutput("pre-reset a.addr_err", 32'(a_addr_err), 32'h1);
        #2 rst = 1'b1;
        wr_en = 1'b0;
        rd_en = '0;
        #1;
        checkOutput("async a.rd_data", a_rd_data, 32'h0);
        checkOutput("async a.rd_valid", 32'(a_rd_valid), 32'h0);
        checkOutput("async a.addr_err", 32'(a_addr_err), 32'h0);
        checkOutput("async b.rd_data0", 32'(b_rd_data[15:0]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b001, 5'd5, 5'd0, 5'd0);
        checkOutput("post-reset R5", 32'(a_rd_data[15:0]), 32'h0000);
        checkOutput("post-reset valid0", 32'(a_rd_valid[0]), 32'h1);

        // Basic write then read.
        applyStimulus(1'b1, 5'd3, 16'h1234, 3'b000, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b001, 5'd3, 5'd0, 5'd0);
        checkOutput("basic a R3", 32'(a_rd_data[15:0]), 32'h1234);
        checkOutput("basic b R3", 32'(b_rd_data[15:0]), 32'h1234);

        // Same-cycle write and read of R7.
        applyStimulus(1'b1, 5'd7, 16'hA5A5, 3'b111, 5'd7, 5'd7, 5'd7);
        checkOutput("bypass a port0", 32'(a_rd_data[15:0]), 32'hA5A5);
        checkOutput("bypass a port1", 32'(a_rd_data[31:16]), 32'hA5A5);
        checkOutput("nobypass b port0", 32'(b_rd_data[15:0]), 32'h0000);
        checkOutput("nobypass b port1", 32'(b_rd_data[31:16]), 32'h0000);
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b111, 5'd7, 5'd7, 5'd7);
        checkOutput("after a port1", 32'(a_rd_data[31:16]), 32'hA5A5);
        checkOutput("after b port2", 32'(b_rd_data[47:32]), 32'hA5A5);

        // Out-of-range accesses on the 20-deep instance.
        applyStimulus(1'b1, 5'd25, 16'hDEAD, 3'b011, 5'd3, 5'd22, 5'd0);
        checkOutput("oor a.addr_err", 32'(a_addr_err), 32'h1);
        checkOutput("oor a.rd_data1", 32'(a_rd_data[31:16]), 32'h0);
        checkOutput("oor a.rd_valid1", 32'(a_rd_valid[1]), 32'h1);
        checkOutput("oor b.addr_err", 32'(b_addr_err), 32'h0);
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b011, 5'd3, 5'd19, 5'd0);
        checkOutput("oor pulse ends", 32'(a_addr_err), 32'h0);
        checkOutput("oor R3 intact", 32'(a_rd_data[15:0]), 32'h1234);
        checkOutput("oor R19 intact", 32'(a_rd_data[31:16]), 32'h0000);

        // Hold while disabled.
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b001, 5'd3, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd3, 16'h5555, 3'b000, 5'd3, 5'd0, 5'd0);
        checkOutput("hold a.rd_data0", 32'(a_rd_data[15:0]), 32'h1234);
        checkOutput("hold a.rd_valid0", 32'(a_rd_valid[0]), 32'h0);

        // R0 behaviour depends on the zero-register build option.
        applyStimulus(1'b1, 5'd0, 16'hFFFF, 3'b000, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b001, 5'd0, 5'd0, 5'd0);
        checkOutput("zero a R0", 32'(a_rd_data[15:0]), ZERO_REG ? 32'h0000 : 32'hFFFF);
        checkOutput("zero a.addr_err", 32'(a_addr_err), 32'h0);

        for (int n = 0; n < 1500; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), rndAddr(), 16'($urandom),
                          3'($urandom_range(0, 7)), rndAddr(), rndAddr(), rndAddr());
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b000, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 16'h0, 3'b000, 5'd0, 5'd0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
